reg_bank_seq: RTL
=================

# reg_bank_seq

Multi-cycle instruction sequencer for the 4-entry register bank (reg_A, reg_B, accumulator). It accepts one ALU instruction at a time over a valid/ready handshake and drives the bank's read and write ports in sequence. It computes the result with an internal 32-bit ALU and writes the result back. It sits between the instruction source and the register bank, and it is the only master of the bank's ports.

## Interface
- No parameters; all widths are fixed: data 32, register address 2, opcode 3.
- CLK  in  1  single clock; rising edge for all controller state
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept an instruction
- in_op  in  3  opcode
- in_rd  in  2  destination register address
- in_rs1  in  2  source 1 register address
- in_rs2  in  2  source 2 register address
- in_imm  in  32  immediate, used only by LI
- opwrite  out  1  bank write enable (1 = write, 0 = read)
- reg_write  out  2  bank write address
- src_1  out  2  bank read address 1
- src_2  out  2  bank read address 2
- data  out  32  bank write data
- data_src_1  in  32  bank read data 1
- data_src_2  in  32  bank read data 2
- done  out  1  one-cycle pulse when the instruction retires
- result  out  32  retired value, held until the next retirement
- flag_z  out  1  result == 0, held until the next retirement
- flag_c  out  1  carry-out for ADD; borrow for SUB (rs1 < rs2 unsigned); 0 for all other opcodes

## Operation
- Register addresses: 00 = A, 01 = B, 10 and 11 = accumulator. Addresses pass through unchanged.
- Opcodes and results (r1 = data_src_1, r2 = data_src_2):
  - 000 ADD: r1 + r2
  - 001 SUB: r1 - r2
  - 010 AND: r1 & r2
  - 011 OR: r1 | r2
  - 100 XOR: r1 ^ r2
  - 101 LI: in_imm
  - 110 MOV: r1
  - 111 NOP: no write; result, flag_z and flag_c are unchanged; done still pulses.
- Arithmetic is modulo 2^32. The carry/borrow is the 33rd bit of the operation.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE. There are no other states, and every instruction, including LI and NOP, takes the same path.
- IDLE: in_ready = 1, opwrite = 0. When in_valid & in_ready is sampled at a rising edge, latch op, rd, rs1, rs2 and imm, then go to READ.
- READ: opwrite = 0; src_1 = rs1 and src_2 = rs2 are registered and stable for the whole cycle. The bank samples them at the closing edge.
- EXEC: opwrite = 0 and the addresses are held. At the closing edge, capture the ALU output from data_src_1/2 into an internal register.
- WRITE: opwrite = 1 (0 for NOP), reg_write = rd, data = ALU register. The bank writes on the falling edge inside this cycle. done = 1. result and flags are updated at the edge that enters WRITE, so they are valid during the done cycle.
- in_ready = 0 in READ, EXEC and WRITE. Instructions offered in those states are not consumed; the source must hold them.
- Read-after-write hazard: the next instruction's READ starts at least one full cycle after the WRITE falling edge, so it always sees the new value.

## Timing
- Reset (RST sampled high): state = IDLE; opwrite, reg_write, src_1, src_2, data, done, result, flag_z and flag_c all = 0. in_ready = 0 while RST is high, then 1 in the first cycle after it is released.
- Latency: accept at edge 0; READ occupies cycle 1, EXEC cycle 2, WRITE plus done cycle 3; in_ready is 1 again in cycle 4.
- Throughput: one instruction per 4 cycles under back-to-back in_valid.
- Reset mid-operation:
  - RST sampled in READ or EXEC: abort with no bank write.
  - RST sampled at the edge closing WRITE: the write has already happened on that cycle's falling edge and is kept. done is not re-pulsed.
- All outputs are registered; none depends combinationally on in_* or data_src_*, except in_ready, which decodes from state and RST.
- rd = 11 writes the accumulator, exactly like rd = 10.

## Test plan
- Reset, then LI rd=00 imm=0x0000_0005 -> opwrite=1, reg_write=00, data=5 in cycle 3; done for one cycle; flag_z=0; in_ready returns in cycle 4.
- Preload A=0xFFFF_FFFF and B=1, then ADD rd=10 rs1=00 rs2=01 -> accumulator=0, result=0, flag_z=1, flag_c=1.
- Preload A=3 and B=5, then SUB rd=11 rs1=00 rs2=01 -> accumulator=0xFFFF_FFFE, flag_c=1; a following MOV rd=01 rs1=10 returns 0xFFFF_FFFE.
- Back-to-back: LI A=7 with in_valid held, then ADD rd=00 rs1=00 rs2=00 -> second instruction accepted exactly at cycle 4; A=14; the second done arrives 4 cycles after the first.
- NOP after a retirement with result=14 -> opwrite stays 0 throughout, done pulses, result/flags unchanged.
- RST pulsed during EXEC of LI A=0x1234 -> A is not written, all outputs are 0, in_ready=1 after release.

Source files
------------

// File: rtl/reg_bank_seq_if.sv
// Bundle of the instruction handshake, register-bank port and retirement status.
// The sequencer takes the master view because it is the sole master of the bank ports.
interface reg_bank_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_rs1;
  logic [1:0]  in_rs2;
  logic [31:0] in_imm;
  logic        opwrite;
  logic [1:0]  reg_write;
  logic [1:0]  src_1;
  logic [1:0]  src_2;
  logic [31:0] data;
  logic [31:0] data_src_1;
  logic [31:0] data_src_2;
  logic        done;
  logic [31:0] result;
  logic        flag_z;
  logic        flag_c;

  modport master (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, data_src_1, data_src_2,
    output in_ready, opwrite, reg_write, src_1, src_2, data, done, result, flag_z, flag_c
  );

  modport slave (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, data_src_1, data_src_2,
    input  in_ready, opwrite, reg_write, src_1, src_2, data, done, result, flag_z, flag_c
  );
endinterface

// File: rtl/reg_bank_seq.sv
// Four-state instruction sequencer: reads two bank registers, runs a 32-bit ALU op,
// writes the result back and reports result/flags with a one-cycle done pulse.
module reg_bank_seq (
  input logic            CLK,
  input logic            RST,
  reg_bank_seq_if.master bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LI  = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t      state_reg;
  logic [2:0]  op_reg;
  logic [1:0]  rd_reg;
  logic [31:0] imm_reg;
  logic [32:0] alu_next;

  assign bus.in_ready = (state_reg == IDLE) && !RST;

  // Bit 32 carries the ADD carry-out or the SUB borrow; zero for logic ops.
  always_comb begin
    alu_next = 33'd0;
    case (op_reg)
      OP_ADD:  alu_next = {1'b0, bus.data_src_1} + {1'b0, bus.data_src_2};
      OP_SUB:  alu_next = {1'b0, bus.data_src_1} - {1'b0, bus.data_src_2};
      OP_AND:  alu_next = {1'b0, bus.data_src_1 & bus.data_src_2};
      OP_OR:   alu_next = {1'b0, bus.data_src_1 | bus.data_src_2};
      OP_XOR:  alu_next = {1'b0, bus.data_src_1 ^ bus.data_src_2};
      OP_LI:   alu_next = {1'b0, imm_reg};
      OP_MOV:  alu_next = {1'b0, bus.data_src_1};
      default: alu_next = 33'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      op_reg        <= 3'd0;
      rd_reg        <= 2'd0;
      imm_reg       <= 32'd0;
      bus.opwrite   <= 1'b0;
      bus.reg_write <= 2'd0;
      bus.src_1     <= 2'd0;
      bus.src_2     <= 2'd0;
      bus.data      <= 32'd0;
      bus.done      <= 1'b0;
      bus.result    <= 32'd0;
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.opwrite <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            op_reg    <= bus.in_op;
            rd_reg    <= bus.in_rd;
            imm_reg   <= bus.in_imm;
            bus.src_1 <= bus.in_rs1;
            bus.src_2 <= bus.in_rs2;
            state_reg <= READ;
          end
        end
        READ: state_reg <= EXEC;
        EXEC: begin
          // Everything the WRITE cycle shows is loaded here so it is valid with done.
          bus.reg_write <= rd_reg;
          bus.done      <= 1'b1;
          if (op_reg != OP_NOP) begin
            bus.opwrite <= 1'b1;
            bus.data    <= alu_next[31:0];
            bus.result  <= alu_next[31:0];
            bus.flag_z  <= (alu_next[31:0] == 32'd0);
            bus.flag_c  <= alu_next[32];
          end
          state_reg <= WRITE;
        end
        WRITE:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
